// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: shared encodings for the MIPS instruction encoder and the
// single-cycle core's control unit.
//   - op_sel_e   : symbolic operation codes accepted by the encoder
//   - OPCODE_* / FUNCT_* : instruction fields the control unit decodes
//   - state_t / ST_* : encoder FSM state encoding
//   - pack_rtype / pack_itype : field packers for the two instruction formats
package mips_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLT = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7
  } op_sel_e;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_LW    = 6'b100011;
  localparam logic [5:0] OPCODE_SW    = 6'b101011;
  localparam logic [5:0] OPCODE_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // {000000, rs, rt, rd, shamt=0, funct}
  function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] funct);
    return {OPCODE_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  // {op, rs, rt, imm}
  function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_format.sv
// mips_instr_format: combinational field packer.
// Ports:
//   i_op_sel  [3:0]  symbolic operation (op_sel_e), 8..15 illegal
//   i_rs/i_rt/i_rd [4:0] register fields (rd unused for I-type)
//   i_imm    [15:0]  immediate / branch offset
//   o_word   [31:0]  packed instruction word
//   o_illegal        op_sel outside the supported set
module mips_instr_format
  import mips_enc_pkg::*;
(
  input  logic [3:0]  i_op_sel,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Illegal ops fall back to an R-type with funct 0; the caller decides
  // whether that word is written, zeroed or dropped.
  always_comb begin
    o_word    = pack_rtype(i_rs, i_rt, i_rd, 6'b000000);
    o_illegal = 1'b0;
    case (i_op_sel)
      OP_ADD:  o_word = pack_rtype(i_rs, i_rt, i_rd, FUNCT_ADD);
      OP_SUB:  o_word = pack_rtype(i_rs, i_rt, i_rd, FUNCT_SUB);
      OP_AND:  o_word = pack_rtype(i_rs, i_rt, i_rd, FUNCT_AND);
      OP_OR:   o_word = pack_rtype(i_rs, i_rt, i_rd, FUNCT_OR);
      OP_SLT:  o_word = pack_rtype(i_rs, i_rt, i_rd, FUNCT_SLT);
      OP_LW:   o_word = pack_itype(OPCODE_LW,  i_rs, i_rt, i_imm);
      OP_SW:   o_word = pack_itype(OPCODE_SW,  i_rs, i_rt, i_imm);
      OP_BEQ:  o_word = pack_itype(OPCODE_BEQ, i_rs, i_rt, i_imm);
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: sequential instruction encoder / program loader.
// Accepts symbolic requests over valid/ready, encodes them and writes the
// words to consecutive instruction-memory addresses starting at 0.
// Ports:
//   clk, reset (async, active-high)
//   start / finish      open / close a load session
//   in_valid / in_ready request handshake (in_ready is registered)
//   op_sel, rs, rt, rd, imm  request payload
//   imem_we, imem_addr, imem_wdata  registered write port, 1-cycle pulse
//   count               words written this session (saturates at PROG_DEPTH)
//   done                session closed
//   err                 sticky illegal-op flag
// Build option: define MIPS_ENC_CHECK_EN to drop illegal ops and flag err;
// otherwise illegal ops are written as 0x00000000 and err is tied low.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned PROG_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam int unsigned    CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PROG_DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                r_in_ready;
  logic                r_imem_we;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_done;
  logic [31:0]         w_word;
  logic [31:0]         w_wdata;
  logic                w_illegal;
  logic                w_xfer;
  logic                w_keep;

  mips_instr_format u_format (
    .i_op_sel  (op_sel),
    .i_rs      (rs),
    .i_rt      (rt),
    .i_rd      (rd),
    .i_imm     (imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // r_in_ready is only ever high in LOAD, so it alone qualifies the transfer.
  assign w_xfer = in_valid & r_in_ready;

`ifdef MIPS_ENC_CHECK_EN
  logic r_err;

  assign w_keep  = ~w_illegal;
  assign w_wdata = w_word;
  assign err     = r_err;

  // Sticky until the next session opens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((w_state_nxt == ST_LOAD) && (r_state != ST_LOAD)) begin
      r_err <= 1'b0;
    end else if (w_xfer && w_illegal) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_keep  = 1'b1;
  assign w_wdata = w_illegal ? 32'h0000_0000 : w_word;
  assign err     = 1'b0;
`endif

  // Next-state, next-count and write-strobe logic.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_we_nxt    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_xfer && w_keep) begin
          w_we_nxt = 1'b1;
          if (r_count != DEPTH_C) begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        if (finish || (w_count_nxt == DEPTH_C)) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and output registers; ready/done look ahead one state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_state_nxt == ST_LOAD) && (w_count_nxt < DEPTH_C);
      r_imem_we  <= w_we_nxt;
      r_done     <= (w_state_nxt == ST_DONE);
      // count < PROG_DEPTH <= 2^ADDR_W here, so the low bits never wrap.
      if (w_we_nxt) begin
        r_imem_addr  <= r_count[ADDR_W-1:0];
        r_imem_wdata <= w_wdata;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign count      = r_count;
  assign done       = r_done;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed self-checking bench for mips_instr_encoder,
// built with ADDR_W=2 / PROG_DEPTH=4 so the full-session boundary is short.
// Honors MIPS_ENC_CHECK_EN for the illegal-op expectations.
`timescale 1ns/1ps
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Write-cycle view: {we, addr, wdata, count, done, in_ready}
  logic [39:0] obs_full;
  // Control view: {we, count, done, in_ready, err}
  logic [6:0]  obs_ctl;
  assign obs_full = {imem_we, imem_addr, imem_wdata, count, done, in_ready};
  assign obs_ctl  = {imem_we, count, done, in_ready, err};

  mips_instr_encoder #(.ADDR_W(2), .PROG_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] i);
    in_valid = 1'b1; op_sel = op; rs = s; rt = t; rd = d; imm = i;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; finish = 0; in_valid = 0;
    op_sel = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    tick(); tick();
    checks++;
    if (obs_full !== 40'h0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_values: got %h err=%b, exp 0", obs_full, err);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs_ctl !== 7'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b exp %b", obs_ctl, 7'b0);
    end
  endtask

  task automatic test_add();
    start = 1; tick(); start = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_ready: got %b", obs_ctl);
    end
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0); tick(); in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd0, 32'h00221820, 3'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_write: got %h", obs_full);
    end
    finish = 1; tick(); finish = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_finish_done: got %b", obs_ctl);
    end
  endtask

  task automatic test_back_to_back();
    start = 1; tick(); start = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL restart_from_done: got %b", obs_ctl);
    end
    req(4'd1, 5'd4, 5'd5, 5'd6, 16'd0); tick();
    checks++;
    if (obs_full !== {1'b1, 2'd0, 32'h00853022, 3'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_sub: got %h", obs_full);
    end
    req(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004); tick();
    checks++;
    if (obs_full !== {1'b1, 2'd1, 32'h8C080004, 3'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_lw: got %h", obs_full);
    end
    req(4'd6, 5'd0, 5'd8, 5'd0, 16'h0008); tick();
    checks++;
    if (obs_full !== {1'b1, 2'd2, 32'hAC080008, 3'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_sw: got %h", obs_full);
    end
    req(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF); tick();
    checks++;
    if (obs_full !== {1'b1, 2'd3, 32'h1022FFFF, 3'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_beq_last: got %h", obs_full);
    end
    tick(); in_valid = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_no_extra_write: got %b", obs_ctl);
    end
  endtask

  task automatic test_full();
    int nwr;
    nwr = 0;
    start = 1; tick(); start = 0;
    req(4'd0, 5'd0, 5'd0, 5'd1, 16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_we) begin
        checks++;
        if ({imem_addr, imem_wdata} !== {2'(nwr), 32'h00000820}) begin
          errors++; $display("FAIL full_write_%0d: got %h exp addr %0d", nwr, {imem_addr, imem_wdata}, nwr);
        end
        nwr++;
      end
    end
    in_valid = 0;
    checks++;
    if (nwr !== 4) begin
      errors++; $display("FAIL full_write_count: got %0d exp 4", nwr);
    end
    checks++;
    if (obs_ctl !== {1'b0, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL full_done: got %b", obs_ctl);
    end
  endtask

  task automatic test_finish_with_xfer();
    start = 1; tick(); start = 0;
    req(4'd3, 5'd7, 5'd8, 5'd9, 16'd0); finish = 1; tick(); finish = 0; in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd0, 32'h00E84825, 3'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL finish_xfer_write: got %h", obs_full);
    end
    tick();
    checks++;
    if (obs_ctl !== {1'b0, 3'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL finish_hold_done: got %b", obs_ctl);
    end
    start = 1; tick(); start = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL finish_restart: got %b", obs_ctl);
    end
    req(4'd2, 5'd1, 5'd2, 5'd3, 16'd0); tick();
    checks++;
    if (obs_full !== {1'b1, 2'd0, 32'h00221824, 3'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL restart_and_addr0: got %h", obs_full);
    end
    req(4'd4, 5'd2, 5'd3, 5'd4, 16'd0); tick(); in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd1, 32'h0043202A, 3'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL restart_slt: got %h", obs_full);
    end
  endtask

  task automatic test_illegal();
    req(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234); tick();
`ifdef MIPS_ENC_CHECK_EN
    checks++;
    if (obs_ctl !== {1'b0, 3'd2, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL illegal_dropped: got %b", obs_ctl);
    end
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0); tick(); in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd2, 32'h00221820, 3'd3, 1'b0, 1'b1} || err !== 1'b1) begin
      errors++; $display("FAIL illegal_next_legal: got %h err=%b", obs_full, err);
    end
`else
    checks++;
    if (obs_full !== {1'b1, 2'd2, 32'h00000000, 3'd3, 1'b0, 1'b1} || err !== 1'b0) begin
      errors++; $display("FAIL illegal_nop_write: got %h err=%b", obs_full, err);
    end
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0); tick(); in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd3, 32'h00221820, 3'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL illegal_next_legal: got %h", obs_full);
    end
`endif
    finish = 1; tick(); finish = 0;
  endtask

  task automatic test_reset_mid_write();
    start = 1; tick(); start = 0;
    checks++;
    if (obs_ctl !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL session_clears_err: got %b", obs_ctl);
    end
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0); tick(); in_valid = 0;
    checks++;
    if (obs_full !== {1'b1, 2'd0, 32'h00221820, 3'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL pre_reset_write: got %h", obs_full);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_full !== 40'h0 || err !== 1'b0) begin
      errors++; $display("FAIL async_reset_mid_write: got %h err=%b, exp 0", obs_full, err);
    end
    tick(); reset = 1'b0;
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
    tick(); tick(); in_valid = 0;
    checks++;
    if (obs_ctl !== 7'b0) begin
      errors++; $display("FAIL idle_after_mid_reset: got %b", obs_ctl);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_finish_with_xfer();
    test_illegal();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
